// File: rtl/branch_pkg.sv
// Shared constants and types for the branch/PC sequencer.
// Holds RV32I branch funct3 encodings and the sequencer state enum.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_HALT
  } state_t;

endpackage

// File: rtl/branch_pc_unit_if.sv
// Branch request bundle from decode into the PC sequencer.
// The master drives the request; the sequencer samples it as slave.
interface branch_pc_unit_if #(
  parameter int XLEN = 32
);

  logic            stall;
  logic            br_valid;
  logic [2:0]      br_funct3;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] imm;

  modport master (
    output stall, br_valid, br_funct3,
    output br_pc, rs1, rs2, imm
  );

  modport slave (
    input stall, br_valid, br_funct3,
    input br_pc, rs1, rs2, imm
  );

endinterface

// File: rtl/branch_cmp.sv
// Combinational RV32I branch condition evaluator.
// Reserved funct3 codes evaluate as not taken.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            cond
);

  always_comb begin
    cond = 1'b0;
    unique case (funct3)
      F3_BEQ:  cond = (rs1 == rs2);
      F3_BNE:  cond = (rs1 != rs2);
      F3_BLT:  cond = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  cond = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: cond = (rs1 <  rs2);
      F3_BGEU: cond = (rs1 >= rs2);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// PC sequencer: steps by 4 or redirects on taken branches,
// flushes once after a redirect, halts on a misaligned target.
module branch_pc_unit
  import branch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_pc_unit_if.slave    br,
  output logic [XLEN-1:0]    pc,
  output logic               flush,
  output logic               taken,
  output logic               halted,
  output logic [CNT_W-1:0]   br_cnt,
  output logic [CNT_W-1:0]   taken_cnt,
  output logic               led
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_d, target, pc_step;
  logic              flush_d, taken_d, halted_d;
  logic [CNT_W-1:0]  br_cnt_d, taken_cnt_d;
  logic [CNT_W-1:0]  br_inc, taken_inc;
  logic              cond;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1    (br.rs1),
    .rs2    (br.rs2),
    .funct3 (br.br_funct3),
    .cond   (cond)
  );

  assign target  = br.br_pc + br.imm;
  assign pc_step = pc + XLEN'(PC_STEP);

  assign br_inc    = (br_cnt == CNT_MAX)
                   ? br_cnt : br_cnt + 1'b1;
  assign taken_inc = (taken_cnt == CNT_MAX)
                   ? taken_cnt : taken_cnt + 1'b1;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc;
    flush_d     = 1'b0;
    taken_d     = 1'b0;
    halted_d    = halted;
    br_cnt_d    = br_cnt;
    taken_cnt_d = taken_cnt;
    unique case (state_q)
      ST_RUN: begin
        if (!br.stall) begin
          pc_d = pc_step;
          if (br.br_valid) begin
            br_cnt_d = br_inc;
            if (cond) begin
              taken_cnt_d = taken_inc;
              if (target[1:0] == 2'b00) begin
                pc_d    = target;
                flush_d = 1'b1;
                taken_d = 1'b1;
                state_d = ST_FLUSH;
              end else begin
                pc_d     = pc;
                halted_d = 1'b1;
                state_d  = ST_HALT;
              end
            end
          end
        end
      end
      // squashed slot: any branch presented here is dropped
      ST_FLUSH: begin
        if (!br.stall) begin
          pc_d    = pc_step;
          state_d = ST_RUN;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pc        <= RESET_PC;
      flush     <= 1'b0;
      taken     <= 1'b0;
      halted    <= 1'b0;
      led       <= 1'b0;
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else begin
      state_q   <= state_d;
      pc        <= pc_d;
      flush     <= flush_d;
      taken     <= taken_d;
      halted    <= halted_d;
      led       <= halted_d;
      br_cnt    <= br_cnt_d;
      taken_cnt <= taken_cnt_d;
    end
  end

endmodule
